// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply datapath.
// Provides default dimensions, the accumulator width rule and signed datapath typedefs
// sized for the default configuration.
package mm_pkg;

   localparam int unsigned MM_MATRIX_DIM = 8;
   localparam int unsigned MM_ADDR_WIDTH = 6;
   localparam int unsigned MM_DATA_WIDTH = 8;

   // Accumulator wide enough to sum dim full-scale signed products without overflow.
   function automatic int unsigned acc_width(input int unsigned data_width,
                                             input int unsigned dim);
      return 2 * data_width + $clog2(dim);
   endfunction

   localparam int unsigned MM_ACC_WIDTH = acc_width(MM_DATA_WIDTH, MM_MATRIX_DIM);

   typedef logic signed [MM_DATA_WIDTH-1:0]   operand_t;
   typedef logic signed [2*MM_DATA_WIDTH-1:0] product_t;
   typedef logic signed [MM_ACC_WIDTH-1:0]    acc_t;

endpackage

// File: rtl/mac_pipe.sv
// Multiply / accumulate register slice.
// S1 registers the signed product of the operand pair; S2 holds the running sum.
// Ports:
//   CLK, rst_n   clock, asynchronous active-low reset
//   op_valid     operands on data_a/data_b belong to a beat (S0 valid)
//   data_a/b     signed operands
//   first        the product currently in S1 opens a new element
//   prod_valid   S1 product valid (consumed by S2 this cycle)
//   sum_next     sum including the S1 product; registered into the accumulator on prod_valid
module mac_pipe
   import mm_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MM_DATA_WIDTH,
   parameter int unsigned ACC_WIDTH  = MM_ACC_WIDTH
) (
   input  logic                         CLK,
   input  logic                         rst_n,
   input  logic                         op_valid,
   input  logic signed [DATA_WIDTH-1:0] data_a,
   input  logic signed [DATA_WIDTH-1:0] data_b,
   input  logic                         first,
   output logic                         prod_valid,
   output logic signed [ACC_WIDTH-1:0]  sum_next
);

   localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

   logic signed [PROD_WIDTH-1:0] prod_d;
   logic signed [PROD_WIDTH-1:0] prod_q;
   logic                         prod_valid_q;
   logic signed [ACC_WIDTH-1:0]  acc_q;

   // Operands widened first so the multiply is evaluated at full product width.
   assign prod_d = PROD_WIDTH'(data_a) * PROD_WIDTH'(data_b);

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         prod_valid_q <= 1'b0;
         prod_q       <= '0;
      end else begin
         prod_valid_q <= op_valid;
         if (op_valid) begin
            prod_q <= prod_d;
         end
      end
   end

   // First product of an element replaces the sum instead of adding to it.
   always_comb begin
      sum_next = ACC_WIDTH'(prod_q);
      if (!first) begin
         sum_next = acc_q + ACC_WIDTH'(prod_q);
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (prod_valid_q) begin
         acc_q <= sum_next;
      end
   end

   assign prod_valid = prod_valid_q;

endmodule

// File: rtl/mac_accumulate.sv
// Multiply-accumulate stage behind the matrix-multiply address FSM.
// Each beat (mac_enable) carries a C index; its operands arrive one cycle later from the
// operand RAMs. MATRIX_DIM products are summed per C element and written out 3 cycles
// after the element's last beat.
// Ports:
//   CLK, rst_n        clock, asynchronous active-low reset
//   mac_enable        beat valid from the FSM
//   addr_c            C element index for the beat
//   data_a, data_b    signed operands, valid the cycle after their beat
//   c_we              one-cycle write strobe per element
//   c_addr, c_data    write address / signed data, held between strobes
//   busy              work in flight or a partial sum held
//   done              pulses with the write of the last C address
//   sat_flag          (MAC_SAT_EN only) pulses with c_we when c_data was clamped
// Build option: define MAC_SAT_EN to clamp c_data instead of wrapping when
// OUT_WIDTH < ACC_WIDTH, and to add the sat_flag output.
module mac_accumulate
   import mm_pkg::*;
#(
   parameter int unsigned MATRIX_DIM = MM_MATRIX_DIM,
   parameter int unsigned ADDR_WIDTH = MM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = MM_DATA_WIDTH,
   parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, MATRIX_DIM),
   parameter int unsigned OUT_WIDTH  = ACC_WIDTH
) (
   input  logic                  CLK,
   input  logic                  rst_n,
   input  logic                  mac_enable,
   input  logic [ADDR_WIDTH-1:0] addr_c,
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic [DATA_WIDTH-1:0] data_b,
   output logic                  c_we,
   output logic [ADDR_WIDTH-1:0] c_addr,
   output logic [OUT_WIDTH-1:0]  c_data,
   output logic                  busy,
   output logic                  done
`ifdef MAC_SAT_EN
   ,
   output logic                  sat_flag
`endif
);

   localparam int unsigned CNT_WIDTH = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1;
   localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(MATRIX_DIM - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MATRIX_DIM * MATRIX_DIM - 1);

   // S0: beat valid and address
   logic                  s0_valid_q;
   logic [ADDR_WIDTH-1:0] s0_addr_q;
   // S1: address travelling alongside the registered product
   logic [ADDR_WIDTH-1:0] s1_addr_q;

   logic [CNT_WIDTH-1:0]  count_d, count_q;
   logic                  prod_valid;
   logic                  first;
   logic                  last;
   logic signed [ACC_WIDTH-1:0] sum_next;

   logic [OUT_WIDTH-1:0]  out_word;
   logic                  c_we_d, c_we_q;
   logic [ADDR_WIDTH-1:0] c_addr_d, c_addr_q;
   logic [OUT_WIDTH-1:0]  c_data_d, c_data_q;
   logic                  done_d, done_q;
`ifdef MAC_SAT_EN
   logic                  out_clamped;
   logic                  sat_d, sat_q;
`endif

   assign first = (count_q == '0);
   assign last  = (count_q == CNT_LAST);

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid_q <= 1'b0;
         s0_addr_q  <= '0;
         s1_addr_q  <= '0;
      end else begin
         s0_valid_q <= mac_enable;
         if (mac_enable) begin
            s0_addr_q <= addr_c;
         end
         if (s0_valid_q) begin
            s1_addr_q <= s0_addr_q;
         end
      end
   end

   mac_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac_pipe (
      .CLK        (CLK),
      .rst_n      (rst_n),
      .op_valid   (s0_valid_q),
      .data_a     (data_a),
      .data_b     (data_b),
      .first      (first),
      .prod_valid (prod_valid),
      .sum_next   (sum_next)
   );

   // Beat counter advances only on products reaching S2, so stalls freeze it.
   always_comb begin
      count_d = count_q;
      if (prod_valid) begin
         count_d = last ? '0 : count_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Output word formation: wrap by truncation, or clamp when saturation is built in.
   if (OUT_WIDTH < ACC_WIDTH) begin : g_narrow
`ifdef MAC_SAT_EN
      localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
         {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
      localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
         {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

      always_comb begin
         out_word    = sum_next[OUT_WIDTH-1:0];
         out_clamped = 1'b0;
         if (sum_next > OUT_MAX) begin
            out_word    = OUT_MAX[OUT_WIDTH-1:0];
            out_clamped = 1'b1;
         end else if (sum_next < OUT_MIN) begin
            out_word    = OUT_MIN[OUT_WIDTH-1:0];
            out_clamped = 1'b1;
         end
      end
`else
      assign out_word = sum_next[OUT_WIDTH-1:0];
`endif
   end else begin : g_full
      assign out_word = sum_next[OUT_WIDTH-1:0];
`ifdef MAC_SAT_EN
      assign out_clamped = 1'b0;
`endif
   end

   // The final product of an element goes straight to the output registers while the
   // accumulator is free to take the next element's first product in the same cycle.
   always_comb begin
      c_we_d   = 1'b0;
      c_addr_d = c_addr_q;
      c_data_d = c_data_q;
      done_d   = 1'b0;
`ifdef MAC_SAT_EN
      sat_d    = 1'b0;
`endif
      if (prod_valid && last) begin
         c_we_d   = 1'b1;
         c_addr_d = s1_addr_q;
         c_data_d = out_word;
         done_d   = (s1_addr_q == ADDR_LAST);
`ifdef MAC_SAT_EN
         sat_d    = out_clamped;
`endif
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         c_we_q   <= 1'b0;
         c_addr_q <= '0;
         c_data_q <= '0;
         done_q   <= 1'b0;
`ifdef MAC_SAT_EN
         sat_q    <= 1'b0;
`endif
      end else begin
         c_we_q   <= c_we_d;
         c_addr_q <= c_addr_d;
         c_data_q <= c_data_d;
         done_q   <= done_d;
`ifdef MAC_SAT_EN
         sat_q    <= sat_d;
`endif
      end
   end

   assign c_we   = c_we_q;
   assign c_addr = c_addr_q;
   assign c_data = c_data_q;
   assign done   = done_q;
`ifdef MAC_SAT_EN
   assign sat_flag = sat_q;
`endif

   // The output strobe counts as a stage, so busy drops the cycle after the last write.
   assign busy = s0_valid_q | prod_valid | (count_q != '0) | c_we_q;

endmodule

// File: tb/tb_mac_accumulate.sv
// Self-checking bench for mac_accumulate: a full-width instance and a 16-bit-output
// instance share stimulus; every write is checked against a scoreboard built from
// plain sum-of-products arithmetic.
module tb_mac_accumulate;
   import mm_pkg::*;

   typedef logic signed [7:0] vec_t [8];
   typedef struct {
      int     addr;
      longint sum;
      int     cyc;
   } exp_t;
   typedef struct {
      int     a;
      int     b;
      longint exp;
   } tv_t;

   logic        CLK = 1'b0;
   logic        rst_n = 1'b0;
   logic        mac_enable = 1'b0;
   logic [5:0]  addr_c = '0;
   logic [7:0]  data_a = '0;
   logic [7:0]  data_b = '0;

   logic        c_we, busy, done;
   logic [5:0]  c_addr;
   logic [18:0] c_data;
   logic        n_we, n_busy, n_done;
   logic [5:0]  n_addr;
   logic [15:0] n_data;
`ifdef MAC_SAT_EN
   logic        sat_flag, n_sat;
`endif

   mac_accumulate u_dut (
      .CLK        (CLK),
      .rst_n      (rst_n),
      .mac_enable (mac_enable),
      .addr_c     (addr_c),
      .data_a     (data_a),
      .data_b     (data_b),
      .c_we       (c_we),
      .c_addr     (c_addr),
      .c_data     (c_data),
      .busy       (busy),
      .done       (done)
`ifdef MAC_SAT_EN
      ,
      .sat_flag   (sat_flag)
`endif
   );

   mac_accumulate #(
      .OUT_WIDTH (16)
   ) u_dut16 (
      .CLK        (CLK),
      .rst_n      (rst_n),
      .mac_enable (mac_enable),
      .addr_c     (addr_c),
      .data_a     (data_a),
      .data_b     (data_b),
      .c_we       (n_we),
      .c_addr     (n_addr),
      .c_data     (n_data),
      .busy       (n_busy),
      .done       (n_done)
`ifdef MAC_SAT_EN
      ,
      .sat_flag   (n_sat)
`endif
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;
   int n_writes = 0;
   int n_done_seen = 0;
   int exp_done = 0;
   int last_we_cyc = 0;
   exp_t sb[$];
   logic signed [7:0] pend_a = '0;
   logic signed [7:0] pend_b = '0;

   function automatic void chk(string name, longint act, longint exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic longint narrow_exp(longint s);
`ifdef MAC_SAT_EN
      if (s > 32767) return 32767;
      if (s < -32768) return -32768;
      return s;
`else
      logic signed [15:0] w;
      w = 16'(s);
      return longint'(w);
`endif
   endfunction

   // Scoreboard: every strobe must match the oldest expected write, in the expected cycle.
   always @(negedge CLK) begin
      if (rst_n) begin
         if (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("missing_write_addr", -1, sb[0].addr);
            void'(sb.pop_front());
         end
         if (c_we) begin
            n_writes++;
            last_we_cyc = cyc;
            if (done) n_done_seen++;
            if (sb.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("write_cycle", cyc, e.cyc);
               chk("c_addr", c_addr, e.addr);
               chk("c_data", longint'($signed(c_data)), e.sum);
               chk("done", done, (e.addr == 63) ? 1 : 0);
               chk("n_we", n_we, 1);
               chk("n_addr", n_addr, e.addr);
               chk("n_data", longint'($signed(n_data)), narrow_exp(e.sum));
`ifdef MAC_SAT_EN
               chk("sat_flag", sat_flag, 0);
               chk("n_sat", n_sat, (e.sum > 32767 || e.sum < -32768) ? 1 : 0);
`endif
            end
         end else begin
            chk("we_idle_done", done, 0);
            chk("we_idle_n_we", n_we, 0);
         end
      end
   end

   // One clock: drive this cycle's beat and the operands of last cycle's beat.
   task automatic cycle(input bit en, input logic [5:0] addr,
                        input logic signed [7:0] a, input logic signed [7:0] b);
      mac_enable = en;
      addr_c = en ? addr : 6'($urandom);
      data_a = pend_a;
      data_b = pend_b;
      pend_a = en ? a : 8'($urandom);
      pend_b = en ? b : 8'($urandom);
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 6'd0, 8'sd0, 8'sd0);
   endtask

   task automatic run_element(input int addr, input vec_t a, input vec_t b,
                              input int stall_after, input int stall_len,
                              input bit use_exp, input longint exp);
      longint s;
      exp_t e;
      s = 0;
      for (int k = 0; k < 8; k++) s += longint'(a[k]) * longint'(b[k]);
      for (int k = 0; k < 8; k++) begin
         if (k == 7) begin
            e.addr = addr;
            e.sum = use_exp ? exp : s;
            e.cyc = cyc + 3;
            sb.push_back(e);
            if (addr == 63) exp_done++;
         end
         cycle(1'b1, 6'(addr), a[k], b[k]);
         if (k == stall_after) idle(stall_len);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_c_we"}, c_we, 0);
      chk({tag, "_c_addr"}, c_addr, 0);
      chk({tag, "_c_data"}, c_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_n_data"}, n_data, 0);
   endtask

   initial begin
      tv_t  tv [6];
      vec_t va, vb;
      int   start, w0;
      bit   seen;

      tv[0] = '{a: 1,    b: 1,    exp: 8};
      tv[1] = '{a: -128, b: -128, exp: 131072};
      tv[2] = '{a: 127,  b: 127,  exp: 129032};
      tv[3] = '{a: -128, b: 127,  exp: -130048};
      tv[4] = '{a: 0,    b: -77,  exp: 0};
      tv[5] = '{a: 3,    b: -2,   exp: -48};

      // Reset state
      @(posedge CLK);
      #1;
      idle(2);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      idle(1);

      // All-ones stream: 64 elements, no gaps, done on the last
      for (int i = 0; i < 64; i++) begin
         for (int k = 0; k < 8; k++) begin
            va[k] = 8'sd1;
            vb[k] = 8'sd1;
         end
         run_element(i, va, vb, -1, 0, 1'b0, 0);
      end
      idle(5);
      chk("ones_writes", n_writes, 64);
      chk("ones_done_count", n_done_seen, 1);

      // Identity times B, B[i] = i-32
      for (int i = 0; i < 64; i++) begin
         for (int k = 0; k < 8; k++) begin
            va[k] = ((i / 8) == k) ? 8'sd1 : 8'sd0;
            vb[k] = 8'(k * 8 + (i % 8) - 32);
         end
         run_element(i, va, vb, -1, 0, 1'b0, 0);
      end
      idle(5);

      // Table of constant-operand elements with hand-computed results
      for (int t = 0; t < 6; t++) begin
         for (int k = 0; k < 8; k++) begin
            va[k] = 8'(tv[t].a);
            vb[k] = 8'(tv[t].b);
         end
         run_element(t, va, vb, -1, 0, 1'b1, tv[t].exp);
      end
      idle(5);

      // Stall: element 10 unstalled, then again with 5 idle cycles after beat 3
      for (int k = 0; k < 8; k++) begin
         va[k] = 8'($urandom);
         vb[k] = 8'($urandom);
      end
      start = cyc;
      run_element(10, va, vb, -1, 0, 1'b0, 0);
      idle(5);
      chk("plain_latency", last_we_cyc - start, 10);
      start = cyc;
      run_element(10, va, vb, 3, 5, 1'b0, 0);
      idle(5);
      chk("stall_latency", last_we_cyc - start, 15);

      // Reset after beat 4 of element 2: partial sum dropped, beat during reset ignored
      w0 = n_writes;
      for (int k = 0; k < 5; k++) cycle(1'b1, 6'd2, 8'($urandom), 8'($urandom));
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      cycle(1'b1, 6'd63, 8'sd5, 8'sd5);
      cycle(1'b0, 6'd0, 8'sd0, 8'sd0);
      check_reset_outputs("midrst_hold");
      rst_n = 1'b1;
      idle(1);
      chk("aborted_no_write", n_writes, w0);
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 8; k++) begin
            va[k] = 8'($urandom);
            vb[k] = 8'($urandom);
         end
         run_element(i, va, vb, -1, 0, 1'b0, 0);
      end
      idle(5);
      chk("post_reset_writes", n_writes, w0 + 3);

      // Single element: one strobe, busy drops the cycle after it
      w0 = n_writes;
      for (int k = 0; k < 8; k++) begin
         va[k] = 8'($urandom);
         vb[k] = 8'($urandom);
      end
      run_element(0, va, vb, -1, 0, 1'b0, 0);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (c_we) seen = 1'b1;
         else idle(1);
      end
      chk("single_we_seen", seen, 1);
      chk("single_busy_at_we", busy, 1);
      idle(1);
      chk("single_busy_after", busy, 0);
      idle(4);
      chk("single_writes", n_writes - w0, 1);

      // Random elements, addresses and stalls
      for (int i = 0; i < 40; i++) begin
         int ad, sa;
         for (int k = 0; k < 8; k++) begin
            va[k] = 8'($urandom);
            vb[k] = 8'($urandom);
         end
         ad = (i % 10 == 9) ? 63 : int'($urandom_range(0, 63));
         sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
         run_element(ad, va, vb, sa, int'($urandom_range(1, 4)), 1'b0, 0);
      end
      idle(8);
      chk("sb_drained", sb.size(), 0);
      chk("done_count", n_done_seen, exp_done);
      chk("final_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mac_accumulate.md
Name: mac_accumulate

Overview:
- Datapath stage directly downstream of the matrix-multiply address/control FSM.
- Consumes the FSM's mac_enable and addr_c, plus the A/B operand words returned by the operand RAMs (1-cycle read latency).
- Multiplies each operand pair and accumulates MATRIX_DIM products per C element.
- Emits one write (address, data, strobe) per element to the C RAM and a done pulse after the last element.

Parameters:
- MATRIX_DIM, 8, square matrix dimension; products per C element.
- ADDR_WIDTH, 6, width of the C address; must hold MATRIX_DIM**2-1.
- DATA_WIDTH, 8, signed operand width.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(MATRIX_DIM), internal accumulator width; overflow-free by construction.
- OUT_WIDTH, ACC_WIDTH, width of the written C word; must be <= ACC_WIDTH.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mac_enable  in  1  beat valid from FSM; operand addresses issued this cycle.
- addr_c  in  ADDR_WIDTH  C element index from FSM, sampled on each beat.
- data_a  in  DATA_WIDTH  signed A operand; valid the cycle after its beat.
- data_b  in  DATA_WIDTH  signed B operand; valid the cycle after its beat.
- c_we  out  1  C RAM write strobe, one-cycle pulse per element.
- c_addr  out  ADDR_WIDTH  C RAM write address.
- c_data  out  OUT_WIDTH  C RAM write data, signed.
- busy  out  1  high while any beat is in flight or a partial sum is held.
- done  out  1  one-cycle pulse coincident with the c_we for address MATRIX_DIM**2-1.

Behaviour:
- Reset (rst_n low, asynchronous): c_we=0, c_addr=0, c_data=0, busy=0, done=0.
- Reset also clears all pipeline valid bits, the beat counter and the accumulator.
- Reset mid-element discards the partial sum; no write is produced.
- Pipeline, for a beat in cycle t:
  - S0 (t): register valid and addr_c.
  - S1 (t+1): register data_a*data_b as a signed 2*DATA_WIDTH product, with valid and addr.
  - S2 (t+2): accumulate.
- Accumulate: the beat counter selects the first product of an element (count==0). On the first product the accumulator loads the sign-extended product; otherwise it adds the product to the current sum.
- The beat counter increments per valid S2 product and wraps MATRIX_DIM-1 -> 0.
- On the product where count==MATRIX_DIM-1:
  - c_data and c_addr are registered from the final sum and the pipelined addr.
  - c_we is high in cycle t+3, so latency from the last beat to c_we is 3 cycles.
- Back-to-back elements need no bubble: the next element's first product restarts the accumulator in the same cycle the previous result is registered.
- Stall: mac_enable low for any number of cycles holds the counter and accumulator. The result equals the unstalled result.
- c_addr/c_data hold their last written values between strobes.
- done: asserted with c_we when the written c_addr == MATRIX_DIM**2-1.
- busy: high while any stage valid bit is set or the counter is nonzero.
- Width rules: internal arithmetic is signed at ACC_WIDTH. Without saturation, c_data is the low OUT_WIDTH bits of the sum (two's-complement wrap).
- Protocol: a beat arriving while in reset is ignored. addr_c is taken at face value, with no checking against the count.

Optional Feature:
- Macro MAC_SAT_EN.
- Defined: when OUT_WIDTH < ACC_WIDTH, c_data clamps to [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1] on overflow. An extra output sat_flag (1 bit, reset 0) pulses with c_we when clamping occurred.
- Undefined: wrap truncation as above; port sat_flag absent.

Decomposition:
- Shared package mm_pkg: MATRIX_DIM, ADDR_WIDTH, DATA_WIDTH defaults; ACC_WIDTH derivation function; signed operand/product/accumulator typedefs.
- One natural sub-module: mac_pipe, the S1 multiply plus S2 accumulate register slice with the first-product load. The top keeps the beat counter, addr pipeline, output registers, busy/done and saturation.

Test Plan:
- A and B all +1, 64 elements streamed continuously -> 64 c_we pulses, c_addr 0..63 in order, every c_data=8, done once with c_addr=63, latency 3 cycles from the last beat.
- A=identity, B[i]=i-32 -> c_data at address i equals i-32 for all 64 elements; no gaps between c_we pulses at 8-cycle spacing.
- All operands -128 -> every c_data=131072 (ACC_WIDTH=19, no overflow). With OUT_WIDTH=16 and MAC_SAT_EN: c_data=32767, sat_flag=1. Without MAC_SAT_EN: c_data=0 (low 16 bits).
- mac_enable deasserted 5 cycles after beat 3 of element 10, then resumed -> c_data at address 10 identical to the unstalled run; c_we delayed by exactly 5 cycles.
- rst_n pulsed low after beat 4 of element 2, then restart from element 0 -> all outputs 0 during reset; no write for the aborted element; the subsequent run matches the golden results.
- Single-element run (8 beats, addr_c=0) -> exactly one c_we; busy falls the cycle after c_we.
